// File: rtl/apb_master.sv
// APB requester: one command at a time over a SETUP/ACCESS transfer, with a
// bounded wait-state timeout and a single-entry response buffer.
module apb_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  localparam int                CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int                TO_LAST_I = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TO_LAST_I);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam bit                TO_EN     = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_psel, w_psel_nxt;
  logic                r_penable, w_penable_nxt;
  logic                r_pwrite, w_pwrite_nxt;
  logic [ADDR_W-1:0]   r_paddr, w_paddr_nxt;
  logic [DATA_W-1:0]   r_pwdata, w_pwdata_nxt;
  logic                r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0]   r_rsp_rdata, w_rsp_rdata_nxt;
  logic                r_rsp_err, w_rsp_err_nxt;
  logic                w_cmd_ready;

  assign w_cmd_ready = (r_state == ST_IDLE) && !r_rsp_valid;

  // Next-state and next-output computation for the transfer FSM
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_psel_nxt      = r_psel;
    w_penable_nxt   = r_penable;
    w_pwrite_nxt    = r_pwrite;
    w_paddr_nxt     = r_paddr;
    w_pwdata_nxt    = r_pwdata;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;

    // Data and error stay put after the handshake; only valid drops
    if (r_rsp_valid && rsp_ready) begin
      w_rsp_valid_nxt = 1'b0;
    end else begin
      w_rsp_valid_nxt = r_rsp_valid;
    end

    case (r_state)
      ST_IDLE: begin
        if (cmd_valid && w_cmd_ready) begin
          w_pwrite_nxt  = cmd_write;
          w_paddr_nxt   = cmd_addr;
          w_pwdata_nxt  = cmd_wdata;
          w_psel_nxt    = 1'b1;
          w_penable_nxt = 1'b0;
          w_state_nxt   = ST_SETUP;
        end else begin
          w_state_nxt   = ST_IDLE;
        end
      end
      ST_SETUP: begin
        w_penable_nxt = 1'b1;
        w_cnt_nxt     = '0;
        w_state_nxt   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready) begin
          w_psel_nxt      = 1'b0;
          w_penable_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_rdata_nxt = r_pwrite ? '0 : prdata;
          w_state_nxt     = ST_IDLE;
        end else if (TO_EN && (r_cnt == TO_LAST)) begin
          w_psel_nxt      = 1'b0;
          w_penable_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b1;
          w_rsp_rdata_nxt = '0;
          w_state_nxt     = ST_IDLE;
        end else if (r_cnt != CNT_MAX) begin
          w_cnt_nxt       = r_cnt + CNT_ONE;
        end else begin
          w_cnt_nxt       = r_cnt;
        end
      end
      default: begin
        w_psel_nxt    = 1'b0;
        w_penable_nxt = 1'b0;
        w_state_nxt   = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_pwrite    <= w_pwrite_nxt;
      r_paddr     <= w_paddr_nxt;
      r_pwdata    <= w_pwdata_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

  assign cmd_ready = w_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master (TIMEOUT=4) followed by a randomized
// protocol run checked against a small transfer model.
module tb_apb_master;

  logic       pclk;
  logic       presetn;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       rsp_valid, rsp_ready, rsp_err;
  logic [7:0] rsp_rdata;
  logic       psel, penable, pwrite, pready;
  logic [7:0] paddr, pwdata, prdata;

  int n_assert = 0;
  int n_fail   = 0;

  apb_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(4)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apb_chk(input string tag, input logic s, input logic e, input logic [7:0] a);
    chk({tag, "_psel"}, {31'd0, psel}, {31'd0, s});
    chk({tag, "_penable"}, {31'd0, penable}, {31'd0, e});
    chk({tag, "_paddr"}, {24'd0, paddr}, {24'd0, a});
  endtask

  task automatic rsp_chk(input string tag, input logic v, input logic er, input logic [7:0] d);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, {31'd0, v});
    chk({tag, "_rsp_err"}, {31'd0, rsp_err}, {31'd0, er});
    chk({tag, "_rsp_rdata"}, {24'd0, rsp_rdata}, {24'd0, d});
  endtask

  task automatic offer(input logic w, input logic [7:0] a, input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
  endtask

  // Randomized-run model state
  logic       m_acc, m_in_access, m_in_setup, m_write;
  logic [7:0] m_addr, m_wdata;
  int         m_waits;
  int         m_cmds;
  int         m_cycles;

  initial begin
    presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00;
    cmd_wdata = 8'h00; rsp_ready = 1'b0; prdata = 8'h00; pready = 1'b1;

    // Reset values
    #2;
    apb_chk("reset", 1'b0, 1'b0, 8'h00);
    chk("reset_pwrite", {31'd0, pwrite}, 32'd0);
    chk("reset_pwdata", {24'd0, pwdata}, 32'd0);
    rsp_chk("reset", 1'b0, 1'b0, 8'h00);
    chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    #10 presetn = 1'b1;
    tick();

    // Write, zero wait states
    offer(1'b1, 8'h05, 8'hA5);
    pready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    apb_chk("wr_setup", 1'b1, 1'b0, 8'h05);
    chk("wr_pwrite", {31'd0, pwrite}, 32'd1);
    chk("wr_pwdata", {24'd0, pwdata}, 32'hA5);
    chk("wr_setup_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    tick();
    apb_chk("wr_access", 1'b1, 1'b1, 8'h05);
    tick();
    apb_chk("wr_done", 1'b0, 1'b0, 8'h05);
    rsp_chk("wr_done", 1'b1, 1'b0, 8'h00);
    chk("wr_done_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("wr_hs_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("wr_hs_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Read with three wait states
    offer(1'b0, 8'h03, 8'hFF);
    pready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    apb_chk("rd_setup", 1'b1, 1'b0, 8'h03);
    tick();
    apb_chk("rd_access1", 1'b1, 1'b1, 8'h03);
    for (int i = 0; i < 3; i++) begin
      tick();
      apb_chk("rd_wait", 1'b1, 1'b1, 8'h03);
      chk("rd_wait_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    end
    pready = 1'b1;
    prdata = 8'h3C;
    tick();
    prdata = 8'h00;
    apb_chk("rd_done", 1'b0, 1'b0, 8'h03);
    rsp_chk("rd_done", 1'b1, 1'b0, 8'h3C);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Timeout: pready held low
    offer(1'b1, 8'h07, 8'h77);
    pready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      apb_chk("to_wait", 1'b1, 1'b1, 8'h07);
    end
    tick();
    apb_chk("to_abort", 1'b0, 1'b0, 8'h07);
    rsp_chk("to_abort", 1'b1, 1'b1, 8'h00);
    offer(1'b0, 8'h09, 8'h00);
    chk("to_cmd_blocked", {31'd0, cmd_ready}, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("to_hs_psel", {31'd0, psel}, 32'd0);
    chk("to_hs_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    apb_chk("to_next_setup", 1'b1, 1'b0, 8'h09);
    pready = 1'b1;
    prdata = 8'h5A;
    tick();
    tick();
    rsp_chk("to_next_done", 1'b1, 1'b0, 8'h5A);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Backpressure: response held for 5 cycles with a second command queued
    offer(1'b1, 8'h21, 8'h12);
    tick();
    offer(1'b0, 8'h22, 8'h00);
    tick();
    tick();
    rsp_chk("bp_first", 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      tick();
      chk("bp_psel", {31'd0, psel}, 32'd0);
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_hs_psel", {31'd0, psel}, 32'd0);
    rsp_chk("bp_hs", 1'b0, 1'b0, 8'h00);
    tick();
    cmd_valid = 1'b0;
    apb_chk("bp_second", 1'b1, 1'b0, 8'h22);
    prdata = 8'hC3;
    tick();
    tick();
    rsp_chk("bp_second_done", 1'b1, 1'b0, 8'hC3);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Reset in the middle of a waited read
    offer(1'b0, 8'h44, 8'h00);
    pready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    apb_chk("rst_pre", 1'b1, 1'b1, 8'h44);
    #2 presetn = 1'b0;
    #1;
    apb_chk("rst_async", 1'b0, 1'b0, 8'h00);
    chk("rst_async_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    #1 presetn = 1'b1;
    tick();
    chk("rst_after_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_after_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    offer(1'b1, 8'h0F, 8'h11);
    pready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    apb_chk("rst_wr_access", 1'b1, 1'b1, 8'h0F);
    chk("rst_wr_pwdata", {24'd0, pwdata}, 32'h11);
    tick();
    rsp_chk("rst_wr_done", 1'b1, 1'b0, 8'h00);
    rsp_ready = 1'b1;
    tick();

    // Randomized run of 200 commands with a transfer model
    m_cmds = 0; m_cycles = 0; m_waits = 0;
    m_write = 1'b0; m_addr = 8'h00; m_wdata = 8'h00;
    while (m_cmds < 200 && m_cycles < 20000) begin
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_write = 1'($urandom_range(0, 1));
      cmd_addr  = 8'($urandom_range(0, 255));
      cmd_wdata = 8'($urandom_range(0, 255));
      pready    = ($urandom_range(0, 3) != 0);
      prdata    = 8'($urandom_range(0, 255));
      rsp_ready = 1'($urandom_range(0, 1));
      m_acc       = cmd_valid && cmd_ready;
      m_in_access = psel && penable;
      m_in_setup  = psel && !penable;
      if (m_acc) begin
        m_write = cmd_write; m_addr = cmd_addr; m_wdata = cmd_wdata;
      end
      tick();
      m_cycles++;
      if (m_acc) begin
        m_cmds++;
        apb_chk("rnd_accept", 1'b1, 1'b0, m_addr);
      end else if (m_in_setup) begin
        apb_chk("rnd_setup", 1'b1, 1'b1, m_addr);
        m_waits = 0;
      end else if (m_in_access) begin
        if (pready) begin
          chk("rnd_done_psel", {31'd0, psel}, 32'd0);
          rsp_chk("rnd_done", 1'b1, 1'b0, m_write ? 8'h00 : prdata);
        end else if (m_waits == 3) begin
          chk("rnd_to_psel", {31'd0, psel}, 32'd0);
          rsp_chk("rnd_to", 1'b1, 1'b1, 8'h00);
        end else begin
          m_waits++;
          apb_chk("rnd_wait", 1'b1, 1'b1, m_addr);
        end
      end else begin
        chk("rnd_idle_psel", {31'd0, psel}, 32'd0);
      end
      chk("rnd_pen_wo_psel", {31'd0, penable & ~psel}, 32'd0);
      chk("rnd_cmd_ready", {31'd0, cmd_ready}, {31'd0, ~psel & ~rsp_valid});
      if (psel) begin
        chk("rnd_paddr_stable", {24'd0, paddr}, {24'd0, m_addr});
        chk("rnd_pwrite_stable", {31'd0, pwrite}, {31'd0, m_write});
        chk("rnd_pwdata_stable", {24'd0, pwdata}, {24'd0, m_wdata});
      end
    end
    chk("rnd_cmd_count", m_cmds, 32'd200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
